// File: rtl/register_bus_sequencer_pkg.sv
// Shared constants and types for the register bus sequencer: command codes,
// reply status codes, sequencer states and status-word field layout.
package register_bus_sequencer_pkg;

  localparam logic [7:0] READ_REGISTER_CMD  = 8'd0;
  localparam logic [7:0] WRITE_REGISTER_CMD = 8'd1;

  typedef enum logic [3:0] {
    ST_OK       = 4'd0,
    ST_BAD_CMD  = 4'd1,
    ST_BAD_ADDR = 4'd2,
    ST_TIMEOUT  = 4'd3
  } status_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_STROBE,
    S_WAIT_ACK,
    S_REPLY
  } seq_state_t;

  localparam int STATUS_CODE_LSB = 0;
  localparam int STATUS_ADDR_LSB = 8;
  localparam int STATUS_CMD_LSB  = 16;

  function automatic logic [31:0] make_status(input status_code_t code,
                                              input logic [7:0]   addr,
                                              input logic [7:0]   cmd);
    logic [31:0] w_status;
    w_status = '0;
    w_status[STATUS_CODE_LSB +: 4] = code;
    w_status[STATUS_ADDR_LSB +: 8] = addr;
    w_status[STATUS_CMD_LSB  +: 8] = cmd;
    return w_status;
  endfunction

endpackage

// File: rtl/register_bus_sequencer_bus_timeout_counter.sv
// Counts WAIT_ACK cycles; o_expired is high in the last allowed cycle
// (count == TIMEOUT_CYCLES-1). Saturates there until cleared.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/register_bus_sequencer.sv
// Runs one strobed register cycle per command packet on the shared register
// bus and returns data + status; i_reset is asynchronous, active-low.
module register_bus_sequencer
  import register_bus_sequencer_pkg::*;
#(
  parameter int NOS_TARGETS    = 8,
  parameter int ADDR_LSB       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [7:0]               i_cmd,
  input  logic [7:0]               i_reg_address,
  input  logic [31:0]              i_reg_data,
  output logic                     o_reply_valid,
  input  logic                     i_reply_ready,
  output logic [31:0]              o_reply_data,
  output logic [31:0]              o_reply_status,
  output logic [NOS_TARGETS-1:0]   o_bus_target_sel,
  output logic [ADDR_LSB-1:0]      o_bus_addr,
  output logic [31:0]              o_bus_wdata,
  output logic                     o_bus_write,
  output logic                     o_bus_read,
  input  logic [NOS_TARGETS-1:0]   i_target_ack,
  input  logic [32*NOS_TARGETS-1:0] i_target_rdata,
  output logic                     o_busy
);

  localparam int IDX_W = 8 - ADDR_LSB;

  seq_state_t   r_state, w_next_state;
  logic [7:0]   r_cmd, r_addr;
  logic [31:0]  r_wdata, r_reply_data;
  status_code_t r_code;

  logic [IDX_W-1:0] w_index;
  logic             w_is_write, w_bad_cmd, w_bad_addr;
  logic             w_ack, w_expired, w_cnt_clear, w_cnt_en;
  logic [31:0]      w_rdata, w_reply_data;
  logic             w_set_reply;
  status_code_t     w_code;

  assign w_index    = r_addr[7:ADDR_LSB];
  assign w_is_write = (r_cmd == WRITE_REGISTER_CMD);
  assign w_bad_cmd  = (r_cmd != READ_REGISTER_CMD) && (r_cmd != WRITE_REGISTER_CMD);
  assign w_bad_addr = ({{(32-IDX_W){1'b0}}, w_index} >= 32'(NOS_TARGETS));

  // Only the addressed target's ack and read data are ever looked at.
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = '0;
    for (int t = 0; t < NOS_TARGETS; t++) begin
      if (w_index == IDX_W'(t)) begin
        w_ack   = i_target_ack[t];
        w_rdata = i_target_rdata[32*t +: 32];
      end
    end
  end

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    o_cmd_ready      = 1'b0;
    o_bus_write      = 1'b0;
    o_bus_read       = 1'b0;
    o_bus_target_sel = '0;
    o_bus_addr       = '0;
    o_bus_wdata      = '0;
    w_cnt_clear      = 1'b0;
    w_cnt_en         = 1'b0;
    w_set_reply      = 1'b0;
    w_code           = ST_OK;
    w_reply_data     = '0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        if (w_bad_cmd || w_bad_addr) begin
          w_set_reply  = 1'b1;
          w_code       = w_bad_cmd ? ST_BAD_CMD : ST_BAD_ADDR;
          w_next_state = S_REPLY;
        end else begin
          w_next_state = S_STROBE;
        end
      end
      S_STROBE: begin
        o_bus_target_sel = {{(NOS_TARGETS-1){1'b0}}, 1'b1} << w_index;
        o_bus_addr       = r_addr[ADDR_LSB-1:0];
        o_bus_wdata      = w_is_write ? r_wdata : '0;
        o_bus_write      = w_is_write;
        o_bus_read       = !w_is_write;
        w_cnt_clear      = 1'b1;
        w_next_state     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (w_ack) begin
          w_set_reply  = 1'b1;
          w_code       = ST_OK;
          w_reply_data = w_is_write ? r_wdata : w_rdata;
          w_next_state = S_REPLY;
        end else if (w_expired) begin
          w_set_reply  = 1'b1;
          w_code       = ST_TIMEOUT;
          w_next_state = S_REPLY;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      S_REPLY: begin
        if (i_reply_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cmd        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_reply_data <= '0;
      r_code       <= ST_OK;
    end else begin
      if ((r_state == S_IDLE) && i_cmd_valid) begin
        r_cmd   <= i_cmd;
        r_addr  <= i_reg_address;
        r_wdata <= i_reg_data;
      end
      if (w_set_reply) begin
        r_reply_data <= w_reply_data;
        r_code       <= w_code;
      end
    end
  end

  assign o_reply_valid  = (r_state == S_REPLY);
  assign o_reply_data   = o_reply_valid ? r_reply_data : '0;
  assign o_reply_status = o_reply_valid ? make_status(r_code, r_addr, r_cmd) : '0;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_register_bus_sequencer.sv
// Scoreboard bench for register_bus_sequencer (TIMEOUT_CYCLES=4): expected
// replies are queued at issue and compared when the DUT presents them.
module tb_register_bus_sequencer;

  localparam int NT = 8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [7:0]      cmd = '0;
  logic [7:0]      reg_address = '0;
  logic [31:0]     reg_data = '0;
  logic            reply_valid;
  logic            reply_ready = 1'b0;
  logic [31:0]     reply_data, reply_status;
  logic [NT-1:0]   bus_target_sel;
  logic [3:0]      bus_addr;
  logic [31:0]     bus_wdata;
  logic            bus_write, bus_read;
  logic [NT-1:0]   target_ack = '0;
  logic [32*NT-1:0] target_rdata = '0;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  register_bus_sequencer #(.NOS_TARGETS(NT), .ADDR_LSB(4), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd            (cmd),
    .i_reg_address    (reg_address),
    .i_reg_data       (reg_data),
    .o_reply_valid    (reply_valid),
    .i_reply_ready    (reply_ready),
    .o_reply_data     (reply_data),
    .o_reply_status   (reply_status),
    .o_bus_target_sel (bus_target_sel),
    .o_bus_addr       (bus_addr),
    .o_bus_wdata      (bus_wdata),
    .o_bus_write      (bus_write),
    .o_bus_read       (bus_read),
    .i_target_ack     (target_ack),
    .i_target_rdata   (target_rdata),
    .o_busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"},
             64'({cmd_ready, reply_valid, busy, bus_write, bus_read, bus_target_sel, bus_addr}),
             64'({1'b1, 16'h0000}));
    check_eq({tag, "_reply"}, {reply_data, reply_status}, 64'h0);
    check_eq({tag, "_wdata"}, 64'(bus_wdata), 64'h0);
  endtask

  // One command: ack_dly/other_tgt < 0 means never; hold = cycles reply_ready stays low.
  task automatic run_txn(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] rdata, input int ack_dly, input int other_tgt,
                         input int exp_code, input int exp_lat, input int hold);
    int k, s, n_strobe, tgt;
    bit done;
    logic [31:0] exp_data, exp_status;
    logic [63:0] got;
    tgt        = int'(a[7:4]);
    exp_data   = (exp_code != 0) ? 32'h0 : ((c == 8'd1) ? d : rdata);
    exp_status = {8'h00, c, a, 4'h0, exp_code[3:0]};
    for (int t = 0; t < NT; t++) target_rdata[32*t +: 32] = 32'hA5A5_0000 + t;
    if (tgt < NT) target_rdata[32*tgt +: 32] = rdata;
    sb_q.push_back({exp_data, exp_status});
    @(negedge clk);
    check_eq("idle_cmd_ready", 64'(cmd_ready), 64'h1);
    cmd_valid = 1'b1; cmd = c; reg_address = a; reg_data = d;
    @(posedge clk);
    k = 0; s = -1; n_strobe = 0; done = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      if (k == 1) check_eq("busy_cmd_ready", 64'({busy, cmd_ready}), 64'h2);
      if (bus_write || bus_read) begin
        n_strobe++;
        s = k;
        check_eq("strobe_cycle", 64'(k), 64'd2);
        check_eq("strobe_sel", 64'(bus_target_sel), 64'(8'h01 << tgt));
        check_eq("strobe_addr", 64'(bus_addr), 64'(a[3:0]));
        check_eq("strobe_wdata", 64'(bus_wdata), 64'((c == 8'd1) ? d : 32'h0));
        check_eq("strobe_kind", 64'({bus_write, bus_read}), (c == 8'd1) ? 64'h2 : 64'h1);
      end
      if (reply_valid) begin
        check_eq("reply_latency", 64'(k), 64'(exp_lat));
        check_eq("sb_not_empty", 64'(sb_q.size() > 0), 64'h1);
        got = (sb_q.size() > 0) ? sb_q.pop_front() : 64'h0;
        check_eq("reply_data", 64'(reply_data), 64'(got[63:32]));
        check_eq("reply_status", 64'(reply_status), 64'(got[31:0]));
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check_eq("hold_reply", {reply_data, reply_status}, got);
          check_eq("hold_flags", 64'({reply_valid, cmd_ready}), 64'h2);
        end
        reply_ready = 1'b1;
        target_ack  = '0;
        @(posedge clk);
        @(negedge clk);
        reply_ready = 1'b0;
        check_eq("post_reply_idle", 64'({reply_valid, cmd_ready, busy}), 64'h2);
        done = 1;
      end else if (s > 0) begin
        if (ack_dly >= 0 && k == s + ack_dly) target_ack[tgt] = 1'b1;
        if (other_tgt >= 0 && k == s + 1) target_ack[other_tgt] = 1'b1;
      end
    end
    if (!done) begin
      check_eq("reply_seen", 64'h0, 64'h1);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    check_eq("strobe_count", 64'(n_strobe), (exp_code == 0 || exp_code == 3) ? 64'h1 : 64'h0);
    target_ack = '0;
    cmd_valid  = 1'b0;
  endtask

  task automatic run_reset_abort();
    int quiet;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 8'd0; reg_address = 8'h30; reg_data = 32'h0;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    target_ack = 8'h08;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (reply_valid || bus_write || bus_read || busy) quiet++;
    end
    check_eq("post_reset_quiet", 64'(quiet), 64'h0);
    target_ack = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_tgt, r_off;
    logic [7:0]  r_cmd;
    logic [31:0] r_d, r_rd;
    int          r_dly;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(8'd1, 8'h00, 32'd100,        32'h0,        2, -1, 0, 5, 0);
    run_txn(8'd0, 8'h12, 32'h0,          32'hDEADBEEF, 1, -1, 0, 4, 0);
    run_txn(8'd7, 8'h00, 32'h1234_5678,  32'h0,       -1, -1, 1, 2, 0);
    run_txn(8'd1, 8'h90, 32'h0000_0055,  32'h0,       -1, -1, 2, 2, 0);
    run_txn(8'd0, 8'h30, 32'h0,          32'hCAFE0003,-1, -1, 3, 3 + TO, 0);
    run_txn(8'd0, 8'h30, 32'h0,          32'hCAFE0033, TO, -1, 0, 3 + TO, 0);
    run_txn(8'd1, 8'h55, 32'h0BAD_F00D,  32'h0,        1, -1, 0, 4, 10);
    run_txn(8'd0, 8'h25, 32'h0,          32'h2222_2222,3,  5, 0, 6, 0);
    run_txn(8'd0, 8'h07, 32'h0,          32'h7777_0007,0, -1, 0, 4, 0);

    run_reset_abort();

    for (int i = 0; i < 6; i++) begin
      r_cmd = 8'($urandom_range(0, 1));
      r_tgt = 4'($urandom_range(0, NT - 1));
      r_off = 4'($urandom_range(0, 15));
      r_d   = $urandom;
      r_rd  = $urandom;
      r_dly = int'($urandom_range(0, 3));
      run_txn(r_cmd, {r_tgt, r_off}, r_d, r_rd, r_dly, -1, 0,
              2 + ((r_dly < 1) ? 1 : r_dly) + 1, 0);
    end

    check_eq("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bus_sequencer.md
Name: register_bus_sequencer

Overview:
Sits between the uP byte-handshake interface and the PWM/QE channel register files. Takes one decoded command packet (command, register address, 32-bit data) and runs a single strobed register cycle on the shared internal register bus to the addressed target. Waits for that target's acknowledge or a timeout, then returns an 8-byte reply (32-bit data plus 32-bit status) to the uP interface. Only one transaction is in flight at a time.

Parameters:
NOS_TARGETS, 8, number of register-bus targets (PWM and QE channels); target_ack width.
ADDR_LSB, 4, target index = reg_address[7:ADDR_LSB]; register offset = reg_address[ADDR_LSB-1:0].
TIMEOUT_CYCLES, 255, clocks allowed in WAIT_ACK before a TIMEOUT reply; range 1..65535.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command packet present
cmd_ready  out  1  sequencer can accept a packet
cmd  in  8  command code
reg_address  in  8  global register address
reg_data  in  32  write data
reply_valid  out  1  reply present
reply_ready  in  1  uP interface takes reply
reply_data  out  32  read data or echoed write data
reply_status  out  32  status word
bus_target_sel  out  NOS_TARGETS  one-hot target select, valid with strobe
bus_addr  out  ADDR_LSB  register offset within target
bus_wdata  out  32  write data
bus_write  out  1  one-cycle write strobe
bus_read  out  1  one-cycle read strobe
target_ack  in  NOS_TARGETS  per-target acknowledge
target_rdata  in  32*NOS_TARGETS  flat per-target read data, target i at [32i+31:32i]
busy  out  1  high whenever state != S_IDLE

Behaviour:
- Reset (async, active-low): state S_IDLE. All outputs 0 except cmd_ready=1. Internal latches and timeout counter cleared.
- S_IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd/reg_address/reg_data, go S_DECODE. cmd_ready=0 in every other state.
- S_DECODE (1 cycle): cmd not READ(0)/WRITE(1) -> status BAD_CMD. Target index >= NOS_TARGETS -> BAD_ADDR. BAD_CMD is checked first. Either error -> S_REPLY with no bus activity and reply_data=0. Otherwise go S_STROBE.
- S_STROBE (exactly 1 cycle): drive bus_target_sel one-hot, bus_addr, and bus_wdata (write; 0 on read). Assert bus_write or bus_read. Clear the timeout counter. Go S_WAIT_ACK.
- S_WAIT_ACK: all strobes and bus_target_sel low. Only target_ack[index] is sampled; acks from other targets are ignored.
  - On ack: for a read, capture the selected target_rdata; for a write, reply_data = latched reg_data. Set status OK and go S_REPLY.
  - Otherwise increment the counter. When the counter == TIMEOUT_CYCLES-1 with no ack: status TIMEOUT, reply_data=0, go S_REPLY.
  - An ack in the same cycle the limit is reached wins: status OK.
  - An ack asserted during S_STROBE is not sampled. Targets must hold ack into the following cycle.
- S_REPLY: reply_valid=1; reply_data and reply_status stable until reply_valid&&reply_ready. Then go S_IDLE next cycle.
- Latency (accept edge = cycle 0): strobe in cycle 2; ack first sampled in cycle 3; ack in cycle N gives reply_valid from cycle N+1. Error path gives reply_valid in cycle 2. Timeout gives reply_valid in cycle 3+TIMEOUT_CYCLES.
- Status word:
  - [3:0] code: 0 OK, 1 BAD_CMD, 2 BAD_ADDR, 3 TIMEOUT.
  - [7:4] = 0.
  - [15:8] echoed reg_address.
  - [23:16] echoed cmd.
  - [31:24] = 0.
- Reset mid-operation: abort immediately. No strobe completes, no reply is issued, and a late target_ack after reset is ignored in S_IDLE.
- Width rules: counter width = $clog2(TIMEOUT_CYCLES+1). Target index is zero-extended for the range compare.

Decomposition:
- Shared package (global constants / types): READ_REGISTER_CMD=0, WRITE_REGISTER_CMD=1, status code enum (OK, BAD_CMD, BAD_ADDR, TIMEOUT), sequencer state enum (S_IDLE, S_DECODE, S_STROBE, S_WAIT_ACK, S_REPLY), and status-word field positions.
- One sub-module, bus_timeout_counter: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- WRITE cmd=1, addr=0x00 (target 0), data=100; target 0 acks 2 cycles after strobe:
  - bus_write high exactly 1 cycle, sel=8'h01, bus_wdata=100.
  - reply_data=100, status=32'h0001_0000.
- READ cmd=0, addr=0x12, target 1 returns 32'hDEADBEEF with ack 1 cycle after strobe:
  - bus_read 1 cycle, sel=8'h02, bus_addr=2.
  - reply_data=DEADBEEF, status=32'h0000_1200.
- cmd=7, addr=0x00 -> no strobe, reply_valid in cycle 2, status=32'h0007_0001, reply_data=0.
- cmd=1, addr=0x90 (index 9 >= 8) -> no strobe, status=32'h0001_9002.
- TIMEOUT_CYCLES=4, READ to target 3 with no ack:
  - reply_valid at cycle 7, status code 3, reply_data=0.
  - A second run with ack exactly at the limit cycle -> status OK.
- Hold reply_ready=0 for 10 cycles -> reply stays stable, cmd_ready stays 0.
- Assert reset during S_WAIT_ACK -> all outputs 0, cmd_ready=1, no reply.
- Ack from a non-selected target during S_WAIT_ACK -> ignored, no reply until the selected target acks.
